// File: rtl/down_counter_ld.sv
// down_counter_ld: loadable down-counter with clock enable and a small
// run-state controller, used for countdown timers and alarm digits.
// Each digit's combinational borrow_out feeds the next digit's ce, so a
// chain of digits moves on the same clock edge.
//
// Optional feature macro: DOWN_CNT_TC_LATCH_EN
//   When this macro is defined, the block gains the tc_clr input and the
//   sticky tc_flag output. tc_flag records that an underflow (borrow)
//   happened, and it stays set until software clears it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | loaded or just reset; ce is ignored until start
// RUN   | counts down on each ce pulse
// PAUSE | stopped by stop; start resumes from the held count
// DONE  | one-shot reached 0; start re-arms only when cnt != 0

module down_counter_ld #(
  parameter int NUMBER_OF_BIT = 4,
  parameter int MAX_VALUE     = 10,
  parameter int RST_INIT      = 0
) (
  input  logic                     clk,
  input  logic                     glob_rst_n,
  input  logic                     ce,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     load,
  input  logic [NUMBER_OF_BIT-1:0] load_val,
  input  logic                     one_shot,
  output logic [NUMBER_OF_BIT-1:0] cnt,
  output logic                     borrow_out,
  output logic                     running,
  output logic                     done
`ifdef DOWN_CNT_TC_LATCH_EN
  ,
  input  logic                     tc_clr,
  output logic                     tc_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Wrap reload value and reset value, sized to the counter width.
  localparam logic [NUMBER_OF_BIT-1:0] TOP_VAL = NUMBER_OF_BIT'(MAX_VALUE - 1);
  localparam logic [NUMBER_OF_BIT-1:0] RST_VAL = NUMBER_OF_BIT'(RST_INIT);
  localparam logic [NUMBER_OF_BIT-1:0] ONE     = NUMBER_OF_BIT'(1);

  state_t                   state;
  state_t                   state_nxt;
  logic [NUMBER_OF_BIT-1:0] cnt_nxt;
  logic [NUMBER_OF_BIT-1:0] load_clamped;
  logic                     cnt_zero;

  // An out-of-range load value saturates to the top of the legal range.
  assign load_clamped = (load_val > TOP_VAL) ? TOP_VAL : load_val;
  assign cnt_zero     = (cnt == '0);

  // Borrow is combinational so that the next digit sees it on the same edge.
  // The reset term forces it low while reset is asserted, with no clock.
  assign borrow_out = glob_rst_n & (state == S_RUN) & ce & cnt_zero & ~load & ~stop;

  // Next-state and next-count decision, in priority order: load, stop, start, count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (load) begin
      cnt_nxt   = load_clamped;
      state_nxt = S_IDLE;
    end else if (stop) begin
      if (state == S_RUN) begin
        state_nxt = S_PAUSE;
      end
    end else if (start) begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_PAUSE: state_nxt = S_RUN;
        S_DONE:  state_nxt = cnt_zero ? S_DONE : S_RUN;
        default: state_nxt = state;
      endcase
    end else if ((state == S_RUN) && ce) begin
      if (!cnt_zero) begin
        cnt_nxt = cnt - ONE;
      end else if (one_shot) begin
        state_nxt = S_DONE;
      end else begin
        cnt_nxt = TOP_VAL;
      end
    end
  end

  // State, count and the registered status decodes of the next state.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      state   <= S_IDLE;
      cnt     <= RST_VAL;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      running <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_DONE);
    end
  end

`ifdef DOWN_CNT_TC_LATCH_EN
  // Sticky underflow flag. If a borrow and a clear happen on the same edge,
  // the borrow wins so the underflow is not lost. A load does not clear it.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      tc_flag <= 1'b0;
    end else if (borrow_out) begin
      tc_flag <= 1'b1;
    end else if (tc_clr) begin
      tc_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_down_counter_ld.sv
// Testbench for down_counter_ld. It runs directed scenarios and then random
// stimulus. The results are checked against a behavioural countdown model.
module tb_down_counter_ld;

  localparam int W    = 4;
  localparam int MAXV = 10;

  logic         clk = 1'b0;
  logic         glob_rst_n;
  logic         ce, start, stop, load, one_shot;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         borrow_out, running, done;
`ifdef DOWN_CNT_TC_LATCH_EN
  logic         tc_clr, tc_flag;
  logic [W-1:0] hi_cnt;
  logic         hi_borrow, hi_running, hi_done, hi_tc;
`else
  logic         tc_clr;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Model state: mode is one of "idle", "run", "pause", "done".
  string m_mode;
  int    m_cnt;
  bit    m_tc;

  always #5 clk = ~clk;

  down_counter_ld #(.NUMBER_OF_BIT(W), .MAX_VALUE(MAXV), .RST_INIT(0)) dut (
    .clk(clk), .glob_rst_n(glob_rst_n), .ce(ce), .start(start), .stop(stop),
    .load(load), .load_val(load_val), .one_shot(one_shot), .cnt(cnt),
    .borrow_out(borrow_out), .running(running), .done(done)
`ifdef DOWN_CNT_TC_LATCH_EN
    , .tc_clr(tc_clr), .tc_flag(tc_flag)
`endif
  );

`ifdef DOWN_CNT_TC_LATCH_EN
  down_counter_ld #(.NUMBER_OF_BIT(W), .MAX_VALUE(MAXV), .RST_INIT(0)) u_hi (
    .clk(clk), .glob_rst_n(glob_rst_n), .ce(borrow_out), .start(start), .stop(stop),
    .load(load), .load_val(load_val), .one_shot(one_shot), .cnt(hi_cnt),
    .borrow_out(hi_borrow), .running(hi_running), .done(hi_done),
    .tc_clr(1'b0), .tc_flag(hi_tc)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = "idle";
    m_cnt  = 0;
    m_tc   = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
    check({tag, ".running"}, 32'(running), 32'(m_mode == "run"));
    check({tag, ".done"}, 32'(done), 32'(m_mode == "done"));
`ifdef DOWN_CNT_TC_LATCH_EN
    check({tag, ".tc_flag"}, 32'(tc_flag), 32'(m_tc));
`endif
  endtask

  // One clock cycle: drive the inputs, check the combinational borrow, advance
  // the model, and then check the registered outputs after the edge.
  task automatic step(input string tag, input logic i_ce, input logic i_start,
                      input logic i_stop, input logic i_load, input int i_lv,
                      input logic i_os, input logic i_clr);
    bit exp_b;
    @(negedge clk);
    ce = i_ce; start = i_start; stop = i_stop; load = i_load;
    load_val = W'(i_lv); one_shot = i_os; tc_clr = i_clr;
    #1;
    exp_b = (m_mode == "run") && i_ce && (m_cnt == 0) && !i_load && !i_stop;
    check({tag, ".borrow"}, 32'(borrow_out), 32'(exp_b));
    if (i_load) begin
      m_cnt  = (i_lv > MAXV - 1) ? MAXV - 1 : i_lv;
      m_mode = "idle";
    end else if (i_stop) begin
      if (m_mode == "run") m_mode = "pause";
    end else if (i_start) begin
      if (m_mode == "idle" || m_mode == "pause") m_mode = "run";
      else if (m_mode == "done" && m_cnt != 0) m_mode = "run";
    end else if (m_mode == "run" && i_ce) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (i_os) m_mode = "done";
      else m_cnt = MAXV - 1;
    end
    if (exp_b) m_tc = 1'b1;
    else if (i_clr) m_tc = 1'b0;
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    glob_rst_n = 1'b0;
    ce = 0; start = 0; stop = 0; load = 0; load_val = '0; one_shot = 0; tc_clr = 0;
    model_reset();
    #12;
    check_regs("por");
    check("por.borrow", 32'(borrow_out), 32'd0);
    @(negedge clk); #1 glob_rst_n = 1'b1;

    // Wrap: load 2, start, then three ce pulses give 1, 0, 9.
    step("wrap_ld",  0, 0, 0, 1, 2, 0, 0);
    step("wrap_st",  0, 1, 0, 0, 0, 0, 0);
    step("wrap_c1",  1, 0, 0, 0, 0, 0, 0);
    step("wrap_c2",  1, 0, 0, 0, 0, 0, 0);
    step("wrap_c3",  1, 0, 0, 0, 0, 0, 0);
    check("wrap.cnt9", 32'(cnt), 32'd9);

    // One-shot: load 1. After start, the count reaches 0 and then DONE.
    // The third ce has no effect.
    step("os_ld",    0, 0, 0, 1, 1, 1, 0);
    step("os_st",    0, 1, 0, 0, 0, 1, 0);
    step("os_c1",    1, 0, 0, 0, 0, 1, 0);
    step("os_c2",    1, 0, 0, 0, 0, 1, 0);
    step("os_c3",    1, 0, 0, 0, 0, 1, 0);
    check("os.done", 32'(done), 32'd1);
    step("os_rest",  0, 1, 0, 0, 0, 1, 0);

    // Priority: at cnt 5 in RUN, load, stop and ce arrive together. Then clamp.
    step("pr_ld",    0, 0, 0, 1, 6, 0, 0);
    step("pr_st",    0, 1, 0, 0, 0, 0, 0);
    step("pr_c",     1, 0, 0, 0, 0, 0, 0);
    step("pr_all",   1, 0, 1, 1, 7, 0, 0);
    check("pr.cnt7", 32'(cnt), 32'd7);
    step("pr_clamp", 0, 0, 0, 1, 12, 0, 0);
    check("pr.cnt9", 32'(cnt), 32'd9);

    // Pause: RUN at 4, stop with ce, hold over 5 ce, start, then ce gives 3.
    step("pa_ld",    0, 0, 0, 1, 4, 0, 0);
    step("pa_st",    0, 1, 0, 0, 0, 0, 0);
    step("pa_stop",  1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("pa_hold", 1, 0, 0, 0, 0, 0, 0);
    step("pa_res",   1, 1, 0, 0, 0, 0, 0);
    step("pa_dec",   1, 0, 0, 0, 0, 0, 0);
    check("pa.cnt3", 32'(cnt), 32'd3);

    // Asynchronous reset mid-run, checked away from any clock edge.
    step("rs_ld",    0, 0, 0, 1, 6, 0, 0);
    step("rs_st",    0, 1, 0, 0, 0, 0, 0);
    step("rs_c",     1, 0, 0, 0, 0, 0, 0);
    ce = 1'b1;
    #2 glob_rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("rst_async");
    check("rst_async.borrow", 32'(borrow_out), 32'd0);
    @(negedge clk); #1 glob_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("rs_nostart", 1, 0, 0, 0, 0, 0, 0);

`ifdef DOWN_CNT_TC_LATCH_EN
    // Cascade of two digits at 00: one ce wraps both digits to 99.
    step("cas_ld",   0, 0, 0, 1, 0, 0, 0);
    step("cas_st",   0, 1, 0, 0, 0, 0, 0);
    step("cas_ce",   1, 0, 0, 0, 0, 0, 0);
    check("cas.hi_cnt", 32'(hi_cnt), 32'd9);
    step("tc_clr",   0, 0, 0, 0, 0, 0, 1);
    step("tc_ld",    0, 0, 0, 1, 0, 0, 0);
    step("tc_st",    0, 1, 0, 0, 0, 0, 0);
    step("tc_both",  1, 0, 0, 0, 0, 0, 1);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step("rand",
           $urandom_range(0, 99) < 65,
           (r >= 20 && r < 35),
           (r >= 10 && r < 20),
           (r < 8),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
